// File: rtl/fu_complete_arbiter.sv
// rtl/fu_complete_arbiter.sv - FU result holding slots with round-robin arbitration into the complete lanes
// Optional same-cycle bypass of empty slots when CDB_BYPASS_EN is defined.
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

package fu_complete_arbiter_pkg;
    typedef struct packed {
        logic        valid;
        logic        take_branch;
        logic [5:0]  rob_idx;
        logic [5:0]  dest_preg;
        logic [31:0] result;
    } fu_complete_packet_t;
endpackage

module fu_complete_arbiter
    import fu_complete_arbiter_pkg::*;
#(
    parameter int NUM_FU = 5,
    parameter int WAYS   = `SUPERSCALAR_WAYS,
    parameter int PTR_W  = $clog2(NUM_FU)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                squash,
    input  fu_complete_packet_t [NUM_FU-1:0]    fu_in,
    output logic [NUM_FU-1:0]                   fu_ready_out,
    output fu_complete_packet_t [WAYS-1:0]      complete_out,
    output logic [$clog2(NUM_FU+1)-1:0]         occupancy
);
    localparam int OCC_W  = $clog2(NUM_FU+1);
    localparam int LANE_W = $clog2(WAYS+1);
    localparam logic [PTR_W:0] NUM_FU_P = (PTR_W+1)'(NUM_FU);

    logic [NUM_FU-1:0]                slot_valid;
    fu_complete_packet_t [NUM_FU-1:0] slot_pkt;
    logic [PTR_W-1:0]                 rr_ptr;

    logic                             block;
    logic [NUM_FU-1:0]                cand;
    fu_complete_packet_t [NUM_FU-1:0] cand_pkt;
    logic [NUM_FU-1:0]                granted;
    logic [PTR_W-1:0]                 rr_ptr_next;
    logic [LANE_W-1:0]                lane_cnt;
    logic                             branch_used;
    logic [PTR_W:0]                   scan_sum;
    logic [PTR_W-1:0]                 idx;
    logic [NUM_FU-1:0]                slot_valid_next;
    fu_complete_packet_t [NUM_FU-1:0] slot_pkt_next;
    logic [OCC_W-1:0]                 occ_next;

    assign block = reset | squash;

`ifdef CDB_BYPASS_EN
    // Bypass stays off in the cycle after reset so complete_out is guaranteed quiet then.
    logic reset_q;

    always_ff @(posedge clock) begin
        reset_q <= reset;
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            cand[i]     = slot_valid[i];
            cand_pkt[i] = slot_pkt[i];
`ifdef CDB_BYPASS_EN
            if (!slot_valid[i] && fu_in[i].valid && !reset_q) begin
                cand[i]     = 1'b1;
                cand_pkt[i] = fu_in[i];
            end
`endif
        end
    end

    // Round-robin scan; a second taken branch is skipped without consuming a lane.
    always_comb begin
        granted      = '0;
        complete_out = '0;
        lane_cnt     = '0;
        branch_used  = 1'b0;
        rr_ptr_next  = rr_ptr;
        scan_sum     = '0;
        idx          = '0;
        if (!block) begin
            for (int k = 0; k < NUM_FU; k++) begin
                scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (scan_sum >= NUM_FU_P) begin
                    scan_sum = scan_sum - NUM_FU_P;
                end
                idx = scan_sum[PTR_W-1:0];
                if (cand[idx] && (lane_cnt < LANE_W'(WAYS))
                        && !(cand_pkt[idx].take_branch && branch_used)) begin
                    granted[idx] = 1'b1;
                    for (int l = 0; l < WAYS; l++) begin
                        if (lane_cnt == LANE_W'(l)) begin
                            complete_out[l] = cand_pkt[idx];
                        end
                    end
                    lane_cnt    = lane_cnt + 1'b1;
                    branch_used = branch_used | cand_pkt[idx].take_branch;
                    rr_ptr_next = (idx == PTR_W'(NUM_FU-1)) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    // A granted slot frees and can be refilled in the same cycle; a bypass grant never lands in the slot.
    always_comb begin
        slot_valid_next = slot_valid;
        slot_pkt_next   = slot_pkt;
        occ_next        = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready_out[i] = block | ~slot_valid[i] | granted[i];
        end
        if (squash) begin
            slot_valid_next = '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (granted[i]) begin
                    slot_valid_next[i] = 1'b0;
                end
                if (fu_in[i].valid && fu_ready_out[i] && !(granted[i] && !slot_valid[i])) begin
                    slot_valid_next[i] = 1'b1;
                    slot_pkt_next[i]   = fu_in[i];
                end
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            occ_next = occ_next + OCC_W'(slot_valid_next[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valid <= '0;
            slot_pkt   <= '0;
            rr_ptr     <= '0;
            occupancy  <= '0;
        end else begin
            slot_valid <= slot_valid_next;
            slot_pkt   <= slot_pkt_next;
            rr_ptr     <= rr_ptr_next;
            occupancy  <= occ_next;
        end
    end
endmodule

// File: tb/tb_fu_complete_arbiter.sv
// tb/tb_fu_complete_arbiter.sv - directed vector table plus randomized reference-model checks for fu_complete_arbiter
module tb_fu_complete_arbiter;
    import fu_complete_arbiter_pkg::*;

    localparam int NUM_FU = 5;
    localparam int WAYS   = 3;
    localparam int NROWS  = 29;
    localparam int NRAND  = 600;

    typedef fu_complete_packet_t pkt_t;

    typedef struct {
        logic             rst;
        logic             sq;
        logic [4:0]       vld;
        logic [4:0]       br;
        logic [4:0]       ready;
        int               occ;
        logic [2:0][8:0]  lanes;
    } vec_t;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    squash;
    pkt_t [NUM_FU-1:0]       fu_in;
    logic [NUM_FU-1:0]       fu_ready_out;
    pkt_t [WAYS-1:0]         complete_out;
    logic [2:0]              occupancy;

    int checks = 0;
    int failures = 0;

    vec_t tbl [NROWS];

    pkt_t              m_pkt [NUM_FU];
    bit                m_valid [NUM_FU];
    int                m_ptr;
    int                m_occ;
    pkt_t              e_lane [WAYS];
    logic [NUM_FU-1:0] e_ready;
    logic [NUM_FU-1:0] e_gr;
    int                e_last;
    pkt_t              pend [NUM_FU];
    bit                pend_v [NUM_FU];

    fu_complete_arbiter #(.NUM_FU(NUM_FU), .WAYS(WAYS)) dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .fu_in        (fu_in),
        .fu_ready_out (fu_ready_out),
        .complete_out (complete_out),
        .occupancy    (occupancy)
    );

    always #5 clock = ~clock;

    function automatic logic [8:0] ln(int f, int r);
        if (f < 0) return 9'd0;
        return {1'b1, 5'(r), 3'(f)};
    endfunction

    function automatic logic [2:0][8:0] lanes3(logic [8:0] a, logic [8:0] b, logic [8:0] c);
        return {c, b, a};
    endfunction

    function automatic vec_t row(logic rst, logic sq, logic [4:0] vld, logic [4:0] br,
                                 logic [4:0] rdy, int occ, logic [2:0][8:0] lanes);
        vec_t v;
        v.rst = rst; v.sq = sq; v.vld = vld; v.br = br;
        v.ready = rdy; v.occ = occ; v.lanes = lanes;
        return v;
    endfunction

    function automatic pkt_t mk_pkt(int fu, int r, logic br);
        pkt_t p;
        p.valid       = 1'b1;
        p.take_branch = br;
        p.rob_idx     = 6'(r);
        p.dest_preg   = 6'(fu);
        p.result      = 32'hC0DE0000 | (r << 8) | fu;
        return p;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_outputs(input logic rst, input logic sq);
        int n;
        int j;
        bit br_seen;
        n = 0;
        br_seen = 0;
        e_gr = '0;
        e_last = -1;
        for (int l = 0; l < WAYS; l++) e_lane[l] = '0;
        if (!rst && !sq) begin
            for (int k = 0; k < NUM_FU; k++) begin
                j = (m_ptr + k) % NUM_FU;
                if (m_valid[j] && n < WAYS && !(m_pkt[j].take_branch && br_seen)) begin
                    e_lane[n] = m_pkt[j];
                    n++;
                    if (m_pkt[j].take_branch) br_seen = 1;
                    e_gr[j] = 1'b1;
                    e_last = j;
                end
            end
        end
        for (int i = 0; i < NUM_FU; i++)
            e_ready[i] = rst || sq || !m_valid[i] || e_gr[i];
    endtask

    task automatic model_update(input logic rst, input logic sq);
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) m_valid[i] = 0;
            m_ptr = 0;
            m_occ = 0;
        end else if (sq) begin
            for (int i = 0; i < NUM_FU; i++) m_valid[i] = 0;
            m_occ = 0;
        end else begin
            m_occ = 0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (e_gr[i]) m_valid[i] = 0;
                if (fu_in[i].valid && e_ready[i]) begin
                    m_valid[i] = 1;
                    m_pkt[i] = fu_in[i];
                end
                if (m_valid[i]) m_occ++;
            end
            if (e_last >= 0) m_ptr = (e_last + 1) % NUM_FU;
        end
    endtask

    initial begin
        pkt_t exp_p;
        logic [8:0] code;
        int fu;
        int rr;

        tbl[0]  = row(1, 0, 5'b00000, 5'b00000, 5'b11111, -1, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[1]  = row(1, 0, 5'b00000, 5'b00000, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[2]  = row(0, 0, 5'b00011, 5'b00000, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[3]  = row(0, 0, 5'b00000, 5'b00000, 5'b11111,  2, lanes3(ln(0,2),  ln(1,2),  ln(-1,0)));
        tbl[4]  = row(0, 0, 5'b11111, 5'b00000, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[5]  = row(0, 0, 5'b00000, 5'b00000, 5'b11100,  5, lanes3(ln(2,4),  ln(3,4),  ln(4,4)));
        tbl[6]  = row(0, 0, 5'b00000, 5'b00000, 5'b11111,  2, lanes3(ln(0,4),  ln(1,4),  ln(-1,0)));
        tbl[7]  = row(1, 0, 5'b00000, 5'b00000, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[8]  = row(0, 0, 5'b11111, 5'b00000, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[9]  = row(0, 0, 5'b00000, 5'b00000, 5'b00111,  5, lanes3(ln(0,8),  ln(1,8),  ln(2,8)));
        tbl[10] = row(0, 0, 5'b00000, 5'b00000, 5'b11111,  2, lanes3(ln(3,8),  ln(4,8),  ln(-1,0)));
        tbl[11] = row(0, 0, 5'b01011, 5'b01010, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[12] = row(0, 0, 5'b00000, 5'b00000, 5'b10111,  3, lanes3(ln(0,11), ln(1,11), ln(-1,0)));
        tbl[13] = row(0, 0, 5'b00000, 5'b00000, 5'b11111,  1, lanes3(ln(3,11), ln(-1,0), ln(-1,0)));
        tbl[14] = row(0, 0, 5'b00011, 5'b00000, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[15] = row(0, 0, 5'b00001, 5'b00000, 5'b11111,  2, lanes3(ln(0,14), ln(1,14), ln(-1,0)));
        tbl[16] = row(0, 0, 5'b01111, 5'b00000, 5'b11111,  1, lanes3(ln(0,15), ln(-1,0), ln(-1,0)));
        tbl[17] = row(0, 1, 5'b10000, 5'b00000, 5'b11111,  4, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[18] = row(0, 0, 5'b00011, 5'b00000, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[19] = row(0, 0, 5'b00000, 5'b00000, 5'b11111,  2, lanes3(ln(1,18), ln(0,18), ln(-1,0)));
        tbl[20] = row(0, 0, 5'b00110, 5'b00000, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[21] = row(0, 0, 5'b11111, 5'b00000, 5'b11111,  2, lanes3(ln(1,20), ln(2,20), ln(-1,0)));
        tbl[22] = row(1, 0, 5'b00000, 5'b00000, 5'b11111,  5, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[23] = row(0, 0, 5'b00011, 5'b00000, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[24] = row(0, 0, 5'b00000, 5'b00000, 5'b11111,  2, lanes3(ln(0,23), ln(1,23), ln(-1,0)));
        tbl[25] = row(0, 0, 5'b11011, 5'b11000, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));
        tbl[26] = row(0, 0, 5'b00000, 5'b00000, 5'b01111,  4, lanes3(ln(3,25), ln(0,25), ln(1,25)));
        tbl[27] = row(0, 0, 5'b00000, 5'b00000, 5'b11111,  1, lanes3(ln(4,25), ln(-1,0), ln(-1,0)));
        tbl[28] = row(0, 0, 5'b00000, 5'b00000, 5'b11111,  0, lanes3(ln(-1,0), ln(-1,0), ln(-1,0)));

        reset = 1'b1;
        squash = 1'b0;
        fu_in = '0;

        for (int r = 0; r < NROWS; r++) begin
            @(negedge clock);
            reset = tbl[r].rst;
            squash = tbl[r].sq;
            for (int i = 0; i < NUM_FU; i++)
                fu_in[i] = tbl[r].vld[i] ? mk_pkt(i, r, tbl[r].br[i]) : pkt_t'('0);
            #1;
            for (int l = 0; l < WAYS; l++) begin
                code = tbl[r].lanes[l];
                fu = int'(code[2:0]);
                rr = int'(code[7:3]);
                exp_p = code[8] ? mk_pkt(fu, rr, tbl[rr].br[fu]) : pkt_t'('0);
                chk($sformatf("row%0d_lane%0d", r, l), 64'(complete_out[l]), 64'(exp_p));
            end
            chk($sformatf("row%0d_ready", r), 64'(fu_ready_out), 64'(tbl[r].ready));
            if (tbl[r].occ >= 0)
                chk($sformatf("row%0d_occ", r), 64'(occupancy), 64'(tbl[r].occ));
        end

        m_occ = -1;
        m_ptr = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            m_valid[i] = 0;
            pend_v[i] = 0;
        end

        for (int c = 0; c < NRAND; c++) begin
            @(negedge clock);
            reset = (c < 2) || ($urandom_range(99) == 0);
            squash = !reset && ($urandom_range(19) == 0);
            model_outputs(reset, squash);
            for (int i = 0; i < NUM_FU; i++) begin
                if (!pend_v[i] && $urandom_range(1) == 1) begin
                    pend[i].valid = 1'b1;
                    pend[i].take_branch = ($urandom_range(2) == 0);
                    pend[i].rob_idx = 6'($urandom);
                    pend[i].dest_preg = 6'($urandom);
                    pend[i].result = $urandom;
                    pend_v[i] = 1;
                end
                fu_in[i] = (pend_v[i] && e_ready[i]) ? pend[i] : pkt_t'('0);
            end
            #1;
            for (int l = 0; l < WAYS; l++)
                chk($sformatf("rand%0d_lane%0d", c, l), 64'(complete_out[l]), 64'(e_lane[l]));
            chk($sformatf("rand%0d_ready", c), 64'(fu_ready_out), 64'(e_ready));
            if (m_occ >= 0)
                chk($sformatf("rand%0d_occ", c), 64'(occupancy), 64'(m_occ));
            for (int i = 0; i < NUM_FU; i++)
                if (fu_in[i].valid) pend_v[i] = 0;
            model_update(reset, squash);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
